// File: rtl/spi_peripheral_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_peripheral_if
// Description : Local-side bus of the SPI mode-0 peripheral. It carries the
//               received-byte stream and the response handshake.
//   o_valid    one-cycle pulse, a received byte is on o_data
//   o_data     received byte
//   o_first    qualifies o_valid: byte is the command byte of the frame
//   o_underrun one-cycle pulse, command byte completed with no response
//   i_valid    response offer from local logic
//   i_ready    response register can accept a response
//   i_data     response data, used bytes sent MSB first
//   i_bytes    response length in bytes (1..3, 0 behaves as 1)
//   modport slave  : the peripheral
//   modport master : local logic
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_peripheral_if #(
  parameter int RESP_W = 24
);
  logic              o_valid;
  logic [7:0]        o_data;
  logic              o_first;
  logic              o_underrun;
  logic              i_valid;
  logic              i_ready;
  logic [RESP_W-1:0] i_data;
  logic [1:0]        i_bytes;

  modport slave (
    output o_valid, o_data, o_first, o_underrun, i_ready,
    input  i_valid, i_data, i_bytes
  );

  modport master (
    input  o_valid, o_data, o_first, o_underrun, i_ready,
    output i_valid, i_data, i_bytes
  );
endinterface
`default_nettype wire

// File: rtl/spi_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : spi_peripheral
// Description : SPI mode-0 (CPOL=0, CPHA=0) target. sclk/csb/mosi are
//               oversampled in the clk domain; every received byte is
//               delivered on the local bus and a locally supplied 1-3 byte
//               response is shifted out on miso right after the command byte.
//   clk   system clock
//   rst   synchronous active-low reset
//   sclk  SPI clock from the controller (asynchronous)
//   csb   chip select, active low (asynchronous)
//   mosi  controller-to-peripheral data (asynchronous)
//   miso  peripheral-to-controller data
//   lcl   local bus (see spi_peripheral_if)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int RESP_W      = 24
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         sclk,
  input  wire logic         csb,
  input  wire logic         mosi,
  output logic              miso,
  spi_peripheral_if.slave   lcl
);

  localparam int c_RESP_BYTES = RESP_W / 8;
  // Cycles until the synchronizers and the csb history flop hold real pin
  // values instead of their reset values.
  localparam int c_FLUSH_DONE = SYNC_STAGES + 1;
  localparam int c_FLUSH_W    = $clog2(c_FLUSH_DONE + 1);

  typedef enum logic [2:0] {
    ST_WAIT_IDLE = 3'd0,
    ST_IDLE      = 3'd1,
    ST_CMD       = 3'd2,
    ST_RESP      = 3'd3,
    ST_DATA      = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_csb_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_csb_d;
  logic [c_FLUSH_W-1:0]   r_flush;
  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_rx_shift;
  logic [RESP_W-1:0]      r_tx_shift;
  logic                   r_pending;
  logic                   r_miso;
  logic                   r_o_valid;
  logic [7:0]             r_o_data;
  logic                   r_o_first;
  logic                   r_o_underrun;

  logic              w_sclk, w_csb, w_mosi;
  logic              w_sclk_rise, w_sclk_fall, w_csb_rise, w_csb_fall;
  logic              w_flushed, w_in_frame, w_bit_rise, w_byte_done, w_cmd_done;
  logic              w_ready, w_accept, w_enter_resp;
  logic [1:0]        w_nbytes;
  logic [RESP_W-1:0] w_resp_aligned;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_csb       = r_csb_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_csb_rise  = w_csb & ~r_csb_d;
  assign w_csb_fall  = ~w_csb & r_csb_d;
  assign w_flushed   = (r_flush == c_FLUSH_W'(c_FLUSH_DONE));

  assign w_in_frame  = (r_state == ST_CMD) || (r_state == ST_RESP) ||
                       (r_state == ST_DATA);
  // A csb rise in the same cycle as an sclk rise discards that bit.
  assign w_bit_rise  = w_sclk_rise && w_in_frame && !w_csb_rise;
  assign w_byte_done = w_bit_rise && (r_bit_cnt == 3'd7);
  assign w_cmd_done  = w_byte_done && (r_state == ST_CMD);

  assign w_accept     = lcl.i_valid && w_ready;
  assign w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);

  // Left-justify the used bytes so the shifter always sends from its MSB.
  assign w_nbytes = (lcl.i_bytes == 2'd0) ? 2'd1 : lcl.i_bytes;
  always_comb begin
    int v_used;
    v_used = int'(w_nbytes);
    if (v_used > c_RESP_BYTES) begin
      v_used = c_RESP_BYTES;
    end
    w_resp_aligned = lcl.i_data << (RESP_W - 8 * v_used);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_WAIT_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      ST_WAIT_IDLE: begin
        if (w_flushed && w_csb) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        w_ready = !r_pending;
        if (w_csb_fall) begin
          w_state_nxt = ST_CMD;
        end
      end
      ST_CMD: begin
        w_ready = !r_pending;
        if (w_csb_rise) begin
          w_state_nxt = ST_IDLE;
        end else if (w_cmd_done) begin
          w_state_nxt = r_pending ? ST_RESP : ST_DATA;
        end
      end
      ST_RESP: begin
        if (w_csb_rise) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        w_ready = !r_pending;
        if (w_csb_rise) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sclk_sync  <= '0;
      r_csb_sync   <= '1;
      r_mosi_sync  <= '0;
      r_sclk_d     <= 1'b0;
      r_csb_d      <= 1'b1;
      r_flush      <= '0;
      r_bit_cnt    <= 3'd0;
      r_rx_shift   <= 7'd0;
      r_tx_shift   <= '0;
      r_pending    <= 1'b0;
      r_miso       <= 1'b0;
      r_o_valid    <= 1'b0;
      r_o_data     <= 8'd0;
      r_o_first    <= 1'b0;
      r_o_underrun <= 1'b0;
    end else begin
      r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_csb_sync   <= {r_csb_sync[SYNC_STAGES-2:0], csb};
      r_mosi_sync  <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_d     <= w_sclk;
      r_csb_d      <= w_csb;
      if (!w_flushed) begin
        r_flush <= r_flush + 1'b1;
      end

      // Partial bytes are discarded whenever the frame ends.
      if (w_bit_rise) begin
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        r_rx_shift <= {r_rx_shift[5:0], w_mosi};
      end else if (!w_in_frame || w_csb_rise) begin
        r_bit_cnt  <= 3'd0;
      end

      r_o_valid    <= w_byte_done;
      r_o_first    <= w_cmd_done;
      r_o_underrun <= w_cmd_done && !r_pending;
      if (w_byte_done) begin
        r_o_data <= {r_rx_shift, w_mosi};
      end

      if (w_accept) begin
        r_pending <= 1'b1;
      end else if (w_enter_resp) begin
        r_pending <= 1'b0;
      end

      // The shifter only holds a pending response outside RESP; zeros are
      // shifted in so bits past the response length come out as 0.
      if (w_accept) begin
        r_tx_shift <= w_resp_aligned;
      end else if ((r_state == ST_RESP) && w_sclk_fall && !w_csb_rise) begin
        r_tx_shift <= {r_tx_shift[RESP_W-2:0], 1'b0};
      end

      if ((r_state == ST_RESP) && !w_csb_rise) begin
        if (w_sclk_fall) begin
          r_miso <= r_tx_shift[RESP_W-1];
        end
      end else begin
        r_miso <= 1'b0;
      end
    end
  end

  assign miso           = r_miso;
  assign lcl.o_valid    = r_o_valid;
  assign lcl.o_data     = r_o_data;
  assign lcl.o_first    = r_o_first;
  assign lcl.o_underrun = r_o_underrun;
  assign lcl.i_ready    = w_ready;

endmodule
`default_nettype wire
